seq_signed_divider: RTL and testbench

Multi-cycle signed integer divider with the same start/done handshake as the team's sequential Booth multiplier, so both arithmetic units share one control style. It computes quotient and remainder of two N-bit two's-complement operands with one radix-2 restoring iteration per clock. It serves as the inverse unit in the datapath: a product from the multiplier, or any dividend, can be divided back by one of its factors.

---
 rtl/seq_signed_divider.sv | 159 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multi-cycle signed restoring divider with start/done handshake
//
// Purpose: computes quotient and remainder of two N-bit two's-complement operands,
// one restoring iteration per clock. Divide-by-zero and the single overflow case
// (-2^(N-1) / -1) are flagged alongside the result.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     signed dividend, sampled on the accepting edge
//   divisor      signed divisor, sampled on the accepting edge
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows the dividend
//   done         result valid, held until the next accepted start or rst
//   busy         high while in RUN or FIX
//   div_by_zero  result qualifier, valid while done=1
//   overflow     result qualifier, valid while done=1
module seq_signed_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  cnt;
    logic [N-1:0]   qmag;       // dividend magnitude, shifted out as quotient bits shift in
    logic [N-1:0]   dmag;       // divisor magnitude
    logic [N:0]     prem;       // partial remainder
    logic           sq;
    logic           sr;
    logic           zero_div;
    logic           ovf_case;

    logic [N-1:0]   dvd_abs;
    logic [N-1:0]   dvs_abs;
    logic [N:0]     shifted;
    logic [N+1:0]   trial;
    logic           last_iter;

    // Negating -2^(N-1) in N bits yields 2^(N-1), which is the correct unsigned magnitude.
    always_comb begin
        dvd_abs   = dividend[N-1] ? -dividend : dividend;
        dvs_abs   = divisor[N-1]  ? -divisor  : divisor;
        shifted   = {prem[N-1:0], qmag[N-1]};
        // One extra top bit so the sign of the trial subtraction is unambiguous.
        trial     = {1'b0, shifted} - {2'b00, dmag};
        last_iter = (cnt == CW'(N - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            cnt         <= '0;
            qmag        <= '0;
            dmag        <= '0;
            prem        <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            zero_div    <= 1'b0;
            ovf_case    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sq          <= dividend[N-1] ^ divisor[N-1];
                        sr          <= dividend[N-1];
                        qmag        <= dvd_abs;
                        dmag        <= dvs_abs;
                        prem        <= '0;
                        cnt         <= '0;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        zero_div    <= (divisor == '0);
                        ovf_case    <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
                    end
                end
                RUN: begin
                    if (trial[N+1]) begin
                        prem <= shifted;
                    end else begin
                        prem <= trial[N:0];
                    end
                    qmag <= {qmag[N-2:0], ~trial[N+1]};
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    // With a zero divisor RUN is skipped, so qmag still holds |dividend|
                    // and re-applying the dividend sign reproduces the dividend.
                    if (zero_div) begin
                        quotient  <= '1;
                        remainder <= sr ? -qmag : qmag;
                    end else begin
                        quotient  <= sq ? -qmag : qmag;
                        remainder <= sr ? -prem[N-1:0] : prem[N-1:0];
                    end
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    overflow    <= ovf_case;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed and random self-checking bench for seq_signed_divider
module tb_seq_signed_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;
    logic         overflow;

    seq_signed_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;
    int edges;
    int busy_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and waits for done. pulse_at > 0 raises start with
    // (pa, pb) for the single edge numbered pulse_at after the accepting edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int pulse_at, input logic [N-1:0] pa, input logic [N-1:0] pb);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start  = 1'b0;
        edges  = 0;
        busy_n = 0;
        while (!done && edges < 40) begin
            if (busy) busy_n++;
            if (edges + 1 == pulse_at) begin
                start    = 1'b1;
                dividend = pa;
                divisor  = pb;
            end
            tick();
            start = 1'b0;
            edges++;
        end
    endtask

    function automatic logic [N-1:0] pick();
        logic [31:0] r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return 16'h7FFF;
            5:       return 16'h0002;
            default: begin
                r = $urandom;
                return r[N-1:0];
            end
        endcase
    endfunction

    initial begin
        logic signed [N-1:0] sa, sb;
        logic [N-1:0]        eq, er, hq, hr;
        logic                edbz, eovf, hold_ok, saw_done;

        vecs[0] = '{16'd7,      16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 1'b0, 17};
        vecs[1] = '{16'hFFF9,   16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17};
        vecs[2] = '{16'd21,     16'd3,    16'd7,    16'd0,    1'b0, 1'b0, 17};
        vecs[3] = '{16'h8001,   16'h7FFF, 16'hFFFF, 16'd0,    1'b0, 1'b0, 17};
        vecs[4] = '{16'h8000,   16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1, 17};
        vecs[5] = '{16'h8000,   16'd1,    16'h8000, 16'd0,    1'b0, 1'b0, 17};
        vecs[6] = '{16'd5,      16'd0,    16'hFFFF, 16'd5,    1'b1, 1'b0, 1};
        vecs[7] = '{16'd100,    16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {quotient, remainder}, 32'h0);
        chk("reset_flags", {28'd0, done, busy, div_by_zero, overflow}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, '0, '0);
            chk($sformatf("v%0d_latency", i), edges, vecs[i].lat);
            chk($sformatf("v%0d_busy_edges", i), busy_n, vecs[i].lat);
            chk($sformatf("v%0d_busy_low_at_done", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_quotient", i), {16'd0, quotient}, {16'd0, vecs[i].q});
            chk($sformatf("v%0d_remainder", i), {16'd0, remainder}, {16'd0, vecs[i].r});
            chk($sformatf("v%0d_flags", i), {30'd0, div_by_zero, overflow},
                {30'd0, vecs[i].dbz, vecs[i].ovf});
            if (i == 0) begin
                hq = quotient;
                hr = remainder;
                hold_ok = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (!done || busy || quotient !== hq || remainder !== hr) hold_ok = 1'b0;
                end
                chk("v0_hold_10_idle", {31'd0, hold_ok}, 32'd1);
            end
        end

        // A start pulse mid-RUN must be ignored.
        run_op(16'd1000, 16'd9, 5, 16'd50, 16'd5);
        chk("busy_start_latency", edges, 17);
        chk("busy_start_quotient", {16'd0, quotient}, 32'd111);
        chk("busy_start_remainder", {16'd0, remainder}, 32'd1);

        // Reset at edge 10 of a restarted operation discards it.
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd9;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_results", {quotient, remainder}, 32'h0);
        chk("rst_mid_flags", {28'd0, done, busy, div_by_zero, overflow}, 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        chk("rst_no_done_after", {31'd0, saw_done}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            sa = pick();
            sb = pick();
            if (sb == 0) begin
                eq = '1; er = sa; edbz = 1'b1; eovf = 1'b0;
            end else if (sa == 16'sh8000 && sb == -16'sd1) begin
                eq = 16'h8000; er = '0; edbz = 1'b0; eovf = 1'b1;
            end else begin
                eq = sa / sb; er = sa % sb; edbz = 1'b0; eovf = 1'b0;
            end
            run_op(sa, sb, 0, '0, '0);
            chk($sformatf("rnd%0d_%0d/%0d", i, sa, sb),
                {quotient, remainder}, {eq, er});
            chk($sformatf("rnd%0d_flags_lat", i),
                {div_by_zero, overflow, 30'(edges)},
                {edbz, eovf, 30'(edbz ? 1 : 17)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
